ysyx_25040111_axi_mem_slave: RTL and testbench
==============================================

Name: ysyx_25040111_axi_mem_slave

Overview:
AXI4 responder (slave) backing a word-addressed memory array. It is the far end of the LSU/IFU AXI master ports in non-SoC simulation builds. It accepts single and INCR/FIXED burst reads and writes and honours byte strobes. It returns OKAY/SLVERR responses with programmable latency. Read and write channels run independent FSMs, each with one transaction outstanding.

Parameters:
BASE, 32'h8000_0000, byte address of word 0
DEPTH, 4096, number of 32-bit words (power of two)
RD_LAT, 2, cycles from AR handshake to first rvalid (>=1)
WR_LAT, 1, cycles from last W beat to bvalid (>=1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
awvalid  in  1  write address valid
awready  out  1  write address ready
awaddr  in  32  write byte address
awid  in  4  write id
awlen  in  8  beats-1
awsize  in  3  bytes per beat = 1<<awsize (0..2)
awburst  in  2  00 FIXED, 01 INCR, 10/11 unsupported
wvalid  in  1  write data valid
wready  out  1  write data ready
wdata  in  32  write data, lane-aligned
wstrb  in  4  byte enables
wlast  in  1  last write beat
bvalid  out  1  write response valid
bready  in  1  write response ready
bresp  out  2  00 OKAY, 10 SLVERR
bid  out  4  echo of awid
arvalid  in  1  read address valid
arready  out  1  read address ready
araddr  in  32  read byte address
arid  in  4  read id
arlen  in  8  beats-1
arsize  in  3  bytes per beat
arburst  in  2  as awburst
rvalid  out  1  read data valid
rready  in  1  read data ready
rdata  out  32  full aligned word containing beat address
rresp  out  2  00 OKAY, 10 SLVERR
rlast  out  1  final read beat
rid  out  4  echo of arid

Behaviour:
- Reset: awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rlast=0, bresp=rresp=00, rdata=0, bid=rid=0. Both FSMs return to IDLE. Memory contents are not cleared. Asserting reset mid-transaction abandons that transaction with no response.
- Word index = (addr-BASE)>>2. The address is in range iff BASE <= addr < BASE+4*DEPTH. Out of range, burst 10/11, or size>2 -> SLVERR for every beat, reads return 0, writes are dropped.
- Beat address: INCR adds 1<<size after each beat (32-bit wrap, no 4KB check). FIXED holds the address constant.
- Read FSM: R_IDLE -> R_WAIT -> R_DATA.
  - R_IDLE: arready=1. On arvalid, latch addr/id/len/size/burst, load latency counter=RD_LAT-1, go to R_WAIT with arready=0.
  - R_WAIT: count down. At 0, read memory at the beat address, assert rvalid, rlast=(len==0), go to R_DATA.
  - R_DATA: rdata/rresp/rlast/rid are held stable while rvalid & !rready. On rvalid&rready: if rlast, drop rvalid and go to R_IDLE (arready=1 next cycle); otherwise advance the address and present the next beat the very next cycle (no bubble).
- Write FSM: W_IDLE -> W_DATA -> W_WAIT -> W_RESP.
  - W_IDLE: awready=1 and wready=0. W beats arriving before AW stall.
  - On AW handshake, latch fields and go to W_DATA with wready=1.
  - Each wvalid&wready beat writes the bytes enabled by wstrb at the beat word. Accumulate an error flag. A beat count mismatch (wlast early, or missing on beat len) sets SLVERR.
  - The beat with wlast, or the beat at count==len, ends data: wready=0, counter=WR_LAT-1, go to W_WAIT.
  - W_WAIT: at 0, go to W_RESP with bvalid=1 and bresp/bid set.
  - W_RESP: hold until bready, then go to W_IDLE.
- Read/write ordering: a write beat and a read-data fetch to the same word on the same edge -> the read returns the old data. The write commits at that edge.
- wstrb=0 beat: accepted, no memory change, OKAY.

Decomposition:
- Shared header ysyx_25040111_inc.vh gains RESP_OKAY=2'b00, RESP_SLVERR=2'b10, BURST_FIXED=2'b00, BURST_INCR=2'b01, and the FSM state encodings.
- One sub-module: ysyx_25040111_axi_beat_addr. It is combinational next-beat address and range/legality check, instantiated once per channel.

Test Plan:
- Single write 0x8000_0010, wdata 0xDEADBEEF, wstrb 1111, then read same -> bresp 00, rdata 0xDEADBEEF, rlast=1, rvalid exactly RD_LAT cycles after AR handshake.
- Byte write 0x8000_0013, wdata 0xAB000000, wstrb 1000 over word 0x11223344 -> read returns 0xAB223344.
- INCR read arlen=3 from 0x8000_0000, rready toggling 1,0,1,1,0,1 -> four beats words 0..3 in order, data stable while stalled, rlast only on beat 4, rid echoed.
- Read araddr 0x7FFF_FFFC and write to BASE+4*DEPTH -> rresp 10, rdata 0; bresp 10; memory unchanged.
- Write burst awlen=2 with wlast on beat 2 -> bresp 10. W presented 3 cycles before AW -> wready stays 0 until after AW handshake.
- Assert rst during R_DATA beat 2 of 4 -> rvalid 0 immediately, arready 1 after release, prior memory contents intact.

Source files
------------

// File: rtl/ysyx_25040111_axi_mem_slave_pkg.sv
// Shared AXI response/burst encodings and FSM state types for the memory responder.
package ysyx_25040111_axi_mem_slave_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_DATA = 2'd2
  } r_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_WAIT = 2'd2,
    W_RESP = 2'd3
  } w_state_t;

  function automatic logic [1:0] resp_of(input logic err);
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/ysyx_25040111_axi_beat_addr.sv
// Combinational beat decode: word index and legality of the current beat address,
// plus the address of the following beat.
module ysyx_25040111_axi_beat_addr
  import ysyx_25040111_axi_mem_slave_pkg::*;
#(
  parameter logic [31:0] BASE  = 32'h8000_0000,
  parameter int          DEPTH = 4096,
  localparam int         AW    = $clog2(DEPTH)
) (
  input  logic [31:0]   addr,
  input  logic [2:0]    size,
  input  logic [1:0]    burst,
  output logic [31:0]   next_addr,
  output logic [AW-1:0] index,
  output logic          err
);

  logic [31:0] offset;
  logic        in_range;
  logic        legal_burst;

  always_comb begin
    // Unsigned wrap of addr-BASE folds the lower and upper bound into one compare.
    offset      = addr - BASE;
    in_range    = offset < 32'(4 * DEPTH);
    legal_burst = (burst == BURST_FIXED) || (burst == BURST_INCR);
    index       = offset[AW+1:2];
    err         = !(in_range && legal_burst && (size <= 3'd2));
    next_addr   = (burst == BURST_FIXED) ? addr : addr + (32'd1 << size);
  end

endmodule

// File: rtl/ysyx_25040111_axi_mem_slave.sv
// AXI4 responder over a word-addressed memory; independent read and write FSMs,
// one outstanding transaction each, programmable response latency.
module ysyx_25040111_axi_mem_slave
  import ysyx_25040111_axi_mem_slave_pkg::*;
#(
  parameter logic [31:0] BASE   = 32'h8000_0000,
  parameter int          DEPTH  = 4096,
  parameter int          RD_LAT = 2,
  parameter int          WR_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awid,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  output logic [3:0]  bid,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic [3:0]  rid
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0] mem [DEPTH];

  r_state_t    r_state;
  logic [31:0] r_addr;
  logic [7:0]  r_len, r_beat, r_cnt;
  logic [2:0]  r_size;
  logic [1:0]  r_burst;
  logic [31:0] r_next;
  logic [AW-1:0] r_index;
  logic        r_err;

  w_state_t    w_state;
  logic [31:0] w_addr;
  logic [7:0]  w_len, w_beat, w_cnt;
  logic [2:0]  w_size;
  logic [1:0]  w_burst;
  logic [3:0]  w_id;
  logic        w_err;
  logic [31:0] w_next;
  logic [AW-1:0] w_index;
  logic        w_beat_err;
  logic        w_fire;

  ysyx_25040111_axi_beat_addr #(.BASE(BASE), .DEPTH(DEPTH)) u_rd_beat (
    .addr(r_addr), .size(r_size), .burst(r_burst),
    .next_addr(r_next), .index(r_index), .err(r_err)
  );

  ysyx_25040111_axi_beat_addr #(.BASE(BASE), .DEPTH(DEPTH)) u_wr_beat (
    .addr(w_addr), .size(w_size), .burst(w_burst),
    .next_addr(w_next), .index(w_index), .err(w_beat_err)
  );

  // r_addr always points at the next beat to fetch, so one decoder serves every fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= R_IDLE;
      arready <= 1'b1;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rresp   <= RESP_OKAY;
      rdata   <= '0;
      rid     <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_cnt   <= '0;
      r_size  <= '0;
      r_burst <= '0;
    end else begin
      case (r_state)
        R_IDLE: if (arvalid) begin
          r_addr  <= araddr;
          rid     <= arid;
          r_len   <= arlen;
          r_size  <= arsize;
          r_burst <= arburst;
          r_cnt   <= 8'(RD_LAT - 1);
          arready <= 1'b0;
          r_state <= R_WAIT;
        end
        R_WAIT: if (r_cnt == 8'd0) begin
          rdata   <= r_err ? 32'd0 : mem[r_index];
          rresp   <= resp_of(r_err);
          r_addr  <= r_next;
          r_beat  <= 8'd0;
          rlast   <= (r_len == 8'd0);
          rvalid  <= 1'b1;
          r_state <= R_DATA;
        end else begin
          r_cnt <= r_cnt - 8'd1;
        end
        R_DATA: if (rready) begin
          if (rlast) begin
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            arready <= 1'b1;
            r_state <= R_IDLE;
          end else begin
            rdata  <= r_err ? 32'd0 : mem[r_index];
            rresp  <= resp_of(r_err);
            r_addr <= r_next;
            r_beat <= r_beat + 8'd1;
            rlast  <= ((r_beat + 8'd1) == r_len);
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state <= W_IDLE;
      awready <= 1'b1;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
      bid     <= '0;
      w_addr  <= '0;
      w_id    <= '0;
      w_len   <= '0;
      w_beat  <= '0;
      w_cnt   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_err   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (awvalid) begin
          w_addr  <= awaddr;
          w_id    <= awid;
          w_len   <= awlen;
          w_size  <= awsize;
          w_burst <= awburst;
          w_beat  <= 8'd0;
          w_err   <= 1'b0;
          awready <= 1'b0;
          wready  <= 1'b1;
          w_state <= W_DATA;
        end
        W_DATA: if (wvalid) begin
          // wlast must coincide exactly with beat len; either disagreement is an error.
          w_err  <= w_err | w_beat_err | (wlast != (w_beat == w_len));
          w_addr <= w_next;
          w_beat <= w_beat + 8'd1;
          if (wlast || (w_beat == w_len)) begin
            wready  <= 1'b0;
            w_cnt   <= 8'(WR_LAT - 1);
            w_state <= W_WAIT;
          end
        end
        W_WAIT: if (w_cnt == 8'd0) begin
          bvalid  <= 1'b1;
          bresp   <= resp_of(w_err);
          bid     <= w_id;
          w_state <= W_RESP;
        end else begin
          w_cnt <= w_cnt - 8'd1;
        end
        W_RESP: if (bready) begin
          bvalid  <= 1'b0;
          awready <= 1'b1;
          w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  assign w_fire = (w_state == W_DATA) && wvalid && wready && !w_beat_err;

  // Contents survive reset; a same-edge read fetch sees the pre-write word.
  always_ff @(posedge clk) begin
    if (w_fire) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[w_index][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_25040111_axi_mem_slave.sv
// Randomized bench for the AXI memory responder, checked against a byte-level memory model.
module tb_ysyx_25040111_axi_mem_slave;

  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam int          DEPTH  = 4096;
  localparam int          RD_LAT = 2;
  localparam int          WR_LAT = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        awvalid = 1'b0, awready;
  logic [31:0] awaddr = '0;
  logic [3:0]  awid = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = '0;
  logic [1:0]  awburst = '0;
  logic        wvalid = 1'b0, wready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        bvalid, bready = 1'b0;
  logic [1:0]  bresp;
  logic [3:0]  bid;
  logic        arvalid = 1'b0, arready;
  logic [31:0] araddr = '0;
  logic [3:0]  arid = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = '0;
  logic [1:0]  arburst = '0;
  logic        rvalid, rready = 1'b0;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;

  int n_vec = 0;
  int n_miscompare = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] exp_q [$];
  logic [1:0]  exp_resp_q [$];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];
  logic [31:0] last_rdata;

  ysyx_25040111_axi_mem_slave #(
    .BASE(BASE), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
    .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rid(rid)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscompare++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // reference model: address legality and beat stepping from plain arithmetic
  function automatic logic ref_legal(input logic [31:0] a, input logic [2:0] s, input logic [1:0] b);
    longint off;
    off = longint'(a) - longint'(BASE);
    return (off >= 0) && (off < longint'(4 * DEPTH)) && (s <= 3'd2) && (b < 2'd2);
  endfunction

  function automatic int ref_index(input logic [31:0] a);
    return int'((longint'(a) - longint'(BASE)) / 4);
  endfunction

  function automatic logic [31:0] ref_step(input logic [31:0] a, input logic [2:0] s, input logic [1:0] b);
    return (b == 2'b00) ? a : a + (32'd1 << s);
  endfunction

  // last_at: beat carrying wlast (len = normal, smaller = early, -1 = never)
  task automatic axi_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int last_at);
    int nsent, n, idx;
    logic err;
    logic [31:0] a;
    nsent = (last_at >= 0 && last_at < int'(len)) ? last_at + 1 : int'(len) + 1;
    a = addr;
    err = (last_at != int'(len));
    for (int i = 0; i < nsent; i++) begin
      if (!ref_legal(a, size, burst)) err = 1'b1;
      else begin
        idx = ref_index(a);
        for (int b = 0; b < 4; b++)
          if (ws[i][b]) ref_mem[idx][8*b +: 8] = wd[i][8*b +: 8];
      end
      a = ref_step(a, size, burst);
    end

    @(posedge clk); #1;
    awvalid = 1'b1; awaddr = addr; awid = id; awlen = len; awsize = size; awburst = burst;
    n = 0;
    do begin @(negedge clk); n++; end while (!awready && n < 50);
    check_eq("awready", 32'(awready), 32'd1);
    check_eq("wready_before_aw", 32'(wready), 32'd0);
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int i = 0; i < nsent; i++) begin
      wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i]; wlast = (i == last_at);
      n = 0;
      do begin @(negedge clk); n++; end while (!wready && n < 50);
      check_eq("wready", 32'(wready), 32'd1);
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bvalid && n < 50);
    check_eq("bvalid", 32'(bvalid), 32'd1);
    check_eq("b_latency", 32'(n - 1), 32'(WR_LAT));
    check_eq("wready_after_last", 32'(wready), 32'd0);
    check_eq("bresp", 32'(bresp), err ? 32'd2 : 32'd0);
    check_eq("bid", 32'(bid), 32'(id));
    @(posedge clk); #1;
    bready = 1'b0;
    @(negedge clk);
    check_eq("bvalid_drop", 32'(bvalid), 32'd0);
    check_eq("awready_back", 32'(awready), 32'd1);
  endtask

  // rr_mode: 0 rready high, 1 pattern 1,0,1,1,0,1, 2 random
  task automatic axi_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int rr_mode);
    int n, beat, cyc, first;
    logic [31:0] a;
    logic [5:0] pat;
    pat = 6'b101101;
    a = addr;
    exp_q.delete(); exp_resp_q.delete();
    for (int i = 0; i <= int'(len); i++) begin
      if (ref_legal(a, size, burst)) begin
        exp_q.push_back(ref_mem[ref_index(a)]); exp_resp_q.push_back(2'b00);
      end else begin
        exp_q.push_back(32'd0); exp_resp_q.push_back(2'b10);
      end
      a = ref_step(a, size, burst);
    end

    @(posedge clk); #1;
    arvalid = 1'b1; araddr = addr; arid = id; arlen = len; arsize = size; arburst = burst;
    n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < 50);
    check_eq("arready", 32'(arready), 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    beat = 0; cyc = 0; first = -1;
    while (beat <= int'(len) && cyc < 400) begin
      case (rr_mode)
        0: rready = 1'b1;
        1: rready = pat[5 - (cyc % 6)];
        default: rready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk); cyc++;
      if (rvalid) begin
        if (first < 0) begin
          first = cyc;
          check_eq("r_latency", 32'(cyc - 1), 32'(RD_LAT));
        end
        check_eq("rdata", rdata, exp_q[0]);
        check_eq("rresp", 32'(rresp), 32'(exp_resp_q[0]));
        check_eq("rlast", 32'(rlast), 32'(beat == int'(len)));
        check_eq("rid", 32'(rid), 32'(id));
        if (rready) begin
          last_rdata = rdata;
          void'(exp_q.pop_front()); void'(exp_resp_q.pop_front());
          beat++;
        end
      end
      @(posedge clk); #1;
    end
    rready = 1'b0;
    check_eq("r_beats", 32'(beat), 32'(len) + 32'd1);
    @(negedge clk);
    check_eq("rvalid_drop", 32'(rvalid), 32'd0);
    check_eq("arready_back", 32'(arready), 32'd1);
  endtask

  initial begin
    int n, last_at;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [31:0] addr;
    logic [3:0]  id;

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_awready", 32'(awready), 32'd1);
    check_eq("rst_arready", 32'(arready), 32'd1);
    check_eq("rst_wready", 32'(wready), 32'd0);
    check_eq("rst_bvalid", 32'(bvalid), 32'd0);
    check_eq("rst_rvalid", 32'(rvalid), 32'd0);
    check_eq("rst_rlast", 32'(rlast), 32'd0);
    check_eq("rst_bresp", 32'(bresp), 32'd0);
    check_eq("rst_rresp", 32'(rresp), 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    check_eq("rst_bid", 32'(bid), 32'd0);
    check_eq("rst_rid", 32'(rid), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // preload words 0..255 with 16-beat INCR bursts
    for (int blk = 0; blk < 16; blk++) begin
      for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      axi_write(BASE + 32'(blk * 64), 4'(blk), 8'd15, 3'd2, 2'b01, 15);
    end

    // single word write/read
    wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
    axi_write(32'h8000_0010, 4'h3, 8'd0, 3'd2, 2'b01, 0);
    axi_read(32'h8000_0010, 4'h4, 8'd0, 3'd2, 2'b01, 0);
    check_eq("deadbeef", last_rdata, 32'hDEAD_BEEF);

    // byte-lane merge
    wd[0] = 32'h1122_3344; ws[0] = 4'hF;
    axi_write(32'h8000_0010, 4'h1, 8'd0, 3'd2, 2'b01, 0);
    wd[0] = 32'hAB00_0000; ws[0] = 4'b1000;
    axi_write(32'h8000_0013, 4'h2, 8'd0, 3'd0, 2'b01, 0);
    axi_read(32'h8000_0010, 4'h5, 8'd0, 3'd2, 2'b01, 0);
    check_eq("byte_merge", last_rdata, 32'hAB22_3344);

    // INCR read with stalled rready
    axi_read(BASE, 4'hA, 8'd3, 3'd2, 2'b01, 1);
    // FIXED read
    axi_read(BASE + 32'd8, 4'h6, 8'd2, 3'd2, 2'b00, 2);

    // out-of-range and illegal bursts
    axi_read(32'h7FFF_FFFC, 4'h7, 8'd0, 3'd2, 2'b01, 0);
    check_eq("oor_rdata", last_rdata, 32'd0);
    wd[0] = 32'h5555_AAAA; ws[0] = 4'hF;
    axi_write(BASE + 32'(4 * DEPTH), 4'h8, 8'd0, 3'd2, 2'b01, 0);
    axi_write(BASE + 32'd20, 4'h9, 8'd0, 3'd2, 2'b10, 0);
    axi_read(BASE, 4'h1, 8'd7, 3'd2, 2'b01, 0);
    axi_read(BASE + 32'd20, 4'h2, 8'd0, 3'd2, 2'b11, 0);

    // W presented before AW, early wlast
    @(posedge clk); #1;
    wvalid = 1'b1; wdata = 32'h0BAD_F00D; wstrb = 4'hF; wlast = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("w_stall_no_aw", 32'(wready), 32'd0);
    end
    for (int i = 0; i < 3; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    axi_write(BASE + 32'd40, 4'hC, 8'd2, 3'd2, 2'b01, 1);
    // missing wlast
    axi_write(BASE + 32'd60, 4'hD, 8'd1, 3'd2, 2'b01, -1);
    // wstrb zero beat
    wd[0] = 32'hFFFF_FFFF; ws[0] = 4'h0;
    axi_write(BASE + 32'd64, 4'hE, 8'd0, 3'd2, 2'b01, 0);
    axi_read(BASE + 32'd40, 4'h3, 8'd7, 3'd2, 2'b01, 2);

    // reset in the middle of a read burst
    @(posedge clk); #1;
    arvalid = 1'b1; araddr = BASE; arid = 4'h9; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01;
    n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < 50);
    @(posedge clk); #1;
    arvalid = 1'b0; rready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!rvalid && n < 50);
    check_eq("mid_rst_beat1", rdata, ref_mem[0]);
    @(posedge clk); #1;
    rready = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_rvalid_beat2", 32'(rvalid), 32'd1);
    check_eq("mid_rst_beat2", rdata, ref_mem[1]);
    #1 rst = 1'b1;
    #1;
    check_eq("rst_rvalid_async", 32'(rvalid), 32'd0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_arready", 32'(arready), 32'd1);
    check_eq("post_rst_rvalid", 32'(rvalid), 32'd0);
    axi_read(BASE, 4'hB, 8'd3, 3'd2, 2'b01, 0);

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      len = 8'($urandom_range(0, 7));
      size = 3'($urandom_range(0, 2));
      if ($urandom_range(0, 11) == 0) size = 3'd3;
      burst = 2'($urandom_range(0, 1));
      if ($urandom_range(0, 11) == 0) burst = 2'($urandom_range(2, 3));
      addr = BASE + 32'($urandom_range(0, 240)) * 32'd4 + ((32'($urandom_range(0, 3)) >> size) << size);
      id = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i <= int'(len); i++) begin
          wd[i] = $urandom; ws[i] = 4'($urandom_range(0, 15));
        end
        last_at = int'(len);
        n = $urandom_range(0, 7);
        if (n == 0 && len > 0) last_at = $urandom_range(0, int'(len) - 1);
        else if (n == 1) last_at = -1;
        axi_write(addr, id, len, size, burst, last_at);
      end else begin
        axi_read(addr, id, len, size, burst, $urandom_range(0, 2));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
    $finish;
  end

endmodule
